// File: rtl/mbinit_param_ctrl_if.sv
// Handshake bundle between the MBINIT top, sideband TX/RX and the parameter checker
// and the PARAM exchange controller.
interface mbinit_param_ctrl_if;
    logic       i_param_en;
    logic       i_sb_rx_valid;
    logic [3:0] i_sb_rx_msg;
    logic       i_sb_tx_ack;
    logic       i_checker_done;
    logic       o_sb_tx_valid;
    logic [3:0] o_sb_tx_msg;
    logic       o_checker_en;
    logic       o_param_done;
    logic       o_param_error;

    modport master (
        output i_param_en, i_sb_rx_valid, i_sb_rx_msg, i_sb_tx_ack, i_checker_done,
        input  o_sb_tx_valid, o_sb_tx_msg, o_checker_en, o_param_done, o_param_error
    );

    modport slave (
        input  i_param_en, i_sb_rx_valid, i_sb_rx_msg, i_sb_tx_ack, i_checker_done,
        output o_sb_tx_valid, o_sb_tx_msg, o_checker_en, o_param_done, o_param_error
    );
endinterface

// File: rtl/mbinit_param_ctrl.sv
// MBINIT PARAM exchange: send own config request, wait for the partner's, run the
// checker, trade responses, and report done or timeout.
module mbinit_param_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000,
    parameter logic [3:0]  MSG_CFG_REQ    = 4'h1,
    parameter logic [3:0]  MSG_CFG_RESP   = 4'h2
) (
    input  logic               CLK,
    input  logic               rst_n,
    mbinit_param_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE, SEND_REQ, WAIT_REQ, CHECK, SEND_RESP, WAIT_RESP, DONE, ERROR
    } state_t;

    state_t             state;
    logic               req_seen;
    logic               resp_seen;
    logic [CNT_W-1:0]   wait_cnt;
    logic               rx_req_hit;
    logic               rx_resp_hit;
    logic               in_wait;
    logic               wait_exit;
    logic               timeout;

    assign rx_req_hit  = (state != IDLE) && bus.i_sb_rx_valid && (bus.i_sb_rx_msg == MSG_CFG_REQ);
    assign rx_resp_hit = (state != IDLE) && bus.i_sb_rx_valid && (bus.i_sb_rx_msg == MSG_CFG_RESP);
    assign timeout     = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 16'd1));

    // Exit condition of each timed wait state; a reception in the current cycle counts.
    always_comb begin
        in_wait   = 1'b0;
        wait_exit = 1'b0;
        case (state)
            SEND_REQ:  begin in_wait = 1'b1; wait_exit = bus.i_sb_tx_ack;           end
            WAIT_REQ:  begin in_wait = 1'b1; wait_exit = req_seen || rx_req_hit;    end
            CHECK:     begin in_wait = 1'b1; wait_exit = bus.i_checker_done;        end
            SEND_RESP: begin in_wait = 1'b1; wait_exit = bus.i_sb_tx_ack;           end
            WAIT_RESP: begin in_wait = 1'b1; wait_exit = resp_seen || rx_resp_hit; end
            default:   begin in_wait = 1'b0; wait_exit = 1'b0;                      end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            req_seen          <= 1'b0;
            resp_seen         <= 1'b0;
            wait_cnt          <= '0;
            bus.o_sb_tx_valid <= 1'b0;
            bus.o_sb_tx_msg   <= 4'h0;
            bus.o_checker_en  <= 1'b0;
            bus.o_param_done  <= 1'b0;
            bus.o_param_error <= 1'b0;
        end else if ((state != IDLE) && !bus.i_param_en) begin
            state             <= IDLE;
            req_seen          <= 1'b0;
            resp_seen         <= 1'b0;
            wait_cnt          <= '0;
            bus.o_sb_tx_valid <= 1'b0;
            bus.o_sb_tx_msg   <= 4'h0;
            bus.o_checker_en  <= 1'b0;
            bus.o_param_done  <= 1'b0;
            bus.o_param_error <= 1'b0;
        end else begin
            if (rx_req_hit)  req_seen  <= 1'b1;
            if (rx_resp_hit) resp_seen <= 1'b1;

            if (in_wait && !wait_exit) begin
                // Exit has priority; timeout only fires when the exit did not happen.
                if (timeout) begin
                    state             <= ERROR;
                    wait_cnt          <= '0;
                    bus.o_sb_tx_valid <= 1'b0;
                    bus.o_sb_tx_msg   <= 4'h0;
                    bus.o_checker_en  <= 1'b0;
                    bus.o_param_error <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end else begin
                case (state)
                    IDLE: if (bus.i_param_en) begin
                        state             <= SEND_REQ;
                        wait_cnt          <= '0;
                        bus.o_sb_tx_valid <= 1'b1;
                        bus.o_sb_tx_msg   <= MSG_CFG_REQ;
                    end
                    SEND_REQ: begin
                        state             <= WAIT_REQ;
                        wait_cnt          <= '0;
                        bus.o_sb_tx_valid <= 1'b0;
                        bus.o_sb_tx_msg   <= 4'h0;
                    end
                    WAIT_REQ: begin
                        state            <= CHECK;
                        wait_cnt         <= '0;
                        bus.o_checker_en <= 1'b1;
                    end
                    CHECK: begin
                        state             <= SEND_RESP;
                        wait_cnt          <= '0;
                        bus.o_sb_tx_valid <= 1'b1;
                        bus.o_sb_tx_msg   <= MSG_CFG_RESP;
                    end
                    SEND_RESP: begin
                        state             <= WAIT_RESP;
                        wait_cnt          <= '0;
                        bus.o_sb_tx_valid <= 1'b0;
                        bus.o_sb_tx_msg   <= 4'h0;
                    end
                    WAIT_RESP: begin
                        state            <= DONE;
                        wait_cnt         <= '0;
                        bus.o_param_done <= 1'b1;
                    end
                    DONE, ERROR: state <= state;
                    default:     state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mbinit_param_ctrl.sv
// Directed bench for mbinit_param_ctrl: nominal, early partner, timeout, backpressure,
// abort and asynchronous reset.
module tb_mbinit_param_ctrl;
    logic CLK = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   xfers  = 0;
    int   x0;
    logic [7:0] outs;

    mbinit_param_ctrl_if bus();

    mbinit_param_ctrl #(
        .TIMEOUT_CYCLES (16'd16),
        .MSG_CFG_REQ    (4'h1),
        .MSG_CFG_RESP   (4'h2)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    assign outs = {bus.o_sb_tx_valid, bus.o_sb_tx_msg, bus.o_checker_en,
                   bus.o_param_done, bus.o_param_error};

    always @(posedge CLK) if (bus.o_sb_tx_valid && bus.i_sb_tx_ack) xfers <= xfers + 1;

    function automatic logic [7:0] o(input logic v, input logic [3:0] m, input logic ce,
                                     input logic d, input logic e);
        return {v, m, ce, d, e};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rx_pulse(input logic [3:0] m);
        bus.i_sb_rx_valid = 1'b1;
        bus.i_sb_rx_msg   = m;
        tick();
        bus.i_sb_rx_valid = 1'b0;
        bus.i_sb_rx_msg   = 4'h0;
    endtask

    task automatic ack_pulse();
        bus.i_sb_tx_ack = 1'b1;
        tick();
        bus.i_sb_tx_ack = 1'b0;
    endtask

    initial begin
        bus.i_param_en     = 1'b0;
        bus.i_sb_rx_valid  = 1'b0;
        bus.i_sb_rx_msg    = 4'h0;
        bus.i_sb_tx_ack    = 1'b0;
        bus.i_checker_done = 1'b0;
        #1 rst_n = 1'b0;
        #11 chk("reset_outputs", outs, 8'h00);
        @(negedge CLK) rst_n = 1'b1;
        tick(); tick();
        chk("idle_after_reset", outs, 8'h00);

        // Nominal exchange
        bus.i_param_en = 1'b1;
        tick();           chk("nom_send_req", outs, o(1, 4'h1, 0, 0, 0));
        tick(); tick();   chk("nom_req_hold", outs, o(1, 4'h1, 0, 0, 0));
        ack_pulse();      chk("nom_wait_req", outs, o(0, 4'h0, 0, 0, 0));
        rx_pulse(4'h3);   chk("nom_ignore_code", outs, o(0, 4'h0, 0, 0, 0));
        rx_pulse(4'h1);   chk("nom_check", outs, o(0, 4'h0, 1, 0, 0));
        tick();           chk("nom_check_hold", outs, o(0, 4'h0, 1, 0, 0));
        bus.i_checker_done = 1'b1;
        tick();
        bus.i_checker_done = 1'b0;
        chk("nom_send_resp", outs, o(1, 4'h2, 1, 0, 0));
        ack_pulse();      chk("nom_wait_resp", outs, o(0, 4'h0, 1, 0, 0));
        rx_pulse(4'h1);   chk("nom_dup_req", outs, o(0, 4'h0, 1, 0, 0));
        rx_pulse(4'h2);   chk("nom_done", outs, o(0, 4'h0, 1, 1, 0));
        tick();           chk("nom_done_hold", outs, o(0, 4'h0, 1, 1, 0));
        bus.i_param_en = 1'b0;
        tick();           chk("nom_release", outs, 8'h00);

        // Early partner request, then abort during CHECK
        bus.i_param_en = 1'b1;
        tick();
        rx_pulse(4'h1);   chk("early_still_req", outs, o(1, 4'h1, 0, 0, 0));
        ack_pulse();      chk("early_wait_req", outs, o(0, 4'h0, 0, 0, 0));
        tick();           chk("early_check", outs, o(0, 4'h0, 1, 0, 0));
        bus.i_param_en = 1'b0;
        tick();           chk("abort_in_check", outs, 8'h00);
        tick();           chk("abort_stays_idle", outs, 8'h00);

        // Timeout in WAIT_REQ
        bus.i_param_en = 1'b1;
        tick();
        ack_pulse();
        repeat (15) tick();
        chk("to_before", outs, o(0, 4'h0, 0, 0, 0));
        tick();           chk("to_error", outs, o(0, 4'h0, 0, 0, 1));
        tick();           chk("to_error_hold", outs, o(0, 4'h0, 0, 0, 1));
        bus.i_param_en = 1'b0;
        tick();           chk("to_release", outs, 8'h00);

        // Exit arriving on the timeout cycle wins
        bus.i_param_en = 1'b1;
        tick();
        ack_pulse();
        repeat (15) tick();
        rx_pulse(4'h1);   chk("to_exit_priority", outs, o(0, 4'h0, 1, 0, 0));
        bus.i_param_en = 1'b0;
        tick();

        // Backpressure on the request
        bus.i_param_en = 1'b1;
        tick();
        x0 = xfers;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold", outs, o(1, 4'h1, 0, 0, 0));
            tick();
        end
        ack_pulse();      chk("bp_released", outs, o(0, 4'h0, 0, 0, 0));
        tick();           chk("bp_no_resend", outs, o(0, 4'h0, 0, 0, 0));
        chk("bp_single_xfer", 8'(xfers - x0), 8'd1);
        bus.i_param_en = 1'b0;
        tick();

        // Reset mid SEND_RESP, then rerun
        bus.i_param_en = 1'b1;
        tick();
        bus.i_sb_rx_valid = 1'b1;
        bus.i_sb_rx_msg   = 4'h1;
        bus.i_sb_tx_ack   = 1'b1;
        tick();
        bus.i_sb_rx_valid = 1'b0;
        bus.i_sb_rx_msg   = 4'h0;
        bus.i_sb_tx_ack   = 1'b0;
        chk("rst_wait_req", outs, o(0, 4'h0, 0, 0, 0));
        tick();           chk("rst_check", outs, o(0, 4'h0, 1, 0, 0));
        bus.i_checker_done = 1'b1;
        tick();
        bus.i_checker_done = 1'b0;
        chk("rst_send_resp", outs, o(1, 4'h2, 1, 0, 0));
        #3 rst_n = 1'b0;
        #1 chk("rst_async", outs, 8'h00);
        tick();           chk("rst_held", outs, 8'h00);
        rst_n = 1'b1;
        tick();           chk("rerun_send_req", outs, o(1, 4'h1, 0, 0, 0));
        ack_pulse();
        rx_pulse(4'h1);   chk("rerun_check", outs, o(0, 4'h0, 1, 0, 0));
        bus.i_checker_done = 1'b1;
        tick();
        bus.i_checker_done = 1'b0;
        chk("rerun_send_resp", outs, o(1, 4'h2, 1, 0, 0));
        ack_pulse();
        rx_pulse(4'h2);   chk("rerun_done", outs, o(0, 4'h0, 1, 1, 0));
        bus.i_param_en = 1'b0;
        tick();           chk("rerun_release", outs, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mbinit_param_ctrl.md
MBINIT_PARAM_CTRL -- requirements
Module: mbinit_param_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd8000, wait-state timeout in CLK cycles.
REQ-002 SHALL have parameter MSG_CFG_REQ, default 4'h1, sideband code for PARAM configuration request.
REQ-003 SHALL have parameter MSG_CFG_RESP, default 4'h2, sideband code for PARAM configuration response.
REQ-004 SHALL have port CLK, input, 1, the block's single clock; all logic on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port i_param_en, input, 1, level request from the MBINIT top to run PARAM; low aborts.
REQ-007 SHALL have port i_sb_rx_valid, input, 1, one-cycle strobe qualifying i_sb_rx_msg.
REQ-008 SHALL have port i_sb_rx_msg, input, 4, decoded received sideband message code.
REQ-009 SHALL have port i_sb_tx_ack, input, 1, sideband TX accepted the message presented this cycle.
REQ-010 SHALL have port i_checker_done, input, 1, parameter checker finished (level).
REQ-011 SHALL have port o_sb_tx_valid, output, 1, TX message request.
REQ-012 SHALL have port o_sb_tx_msg, output, 4, TX message code; valid while o_sb_tx_valid=1.
REQ-013 SHALL have port o_checker_en, output, 1, enable to the parameter checker.
REQ-014 SHALL have port o_param_done, output, 1, PARAM completed successfully (level).
REQ-015 SHALL have port o_param_error, output, 1, PARAM timed out (level).

Function
REQ-016 SHALL implement FSM states IDLE, SEND_REQ, WAIT_REQ, CHECK, SEND_RESP, WAIT_RESP, DONE, ERROR; every output is registered.
REQ-017 SHALL go IDLE->SEND_REQ on the first cycle i_param_en=1.
REQ-018 SHALL, in SEND_REQ, drive o_sb_tx_valid=1 with o_sb_tx_msg=MSG_CFG_REQ, held stable until the cycle i_sb_tx_ack=1, then go to WAIT_REQ with o_sb_tx_valid=0 the next cycle.
REQ-019 SHALL latch a partner-request flag when i_sb_rx_valid=1 and i_sb_rx_msg=MSG_CFG_REQ in any non-IDLE state, including the same cycle as a tx ack.
REQ-020 SHALL go WAIT_REQ->CHECK when the partner-request flag is set (immediately if it was already set on entry).
REQ-021 SHALL hold o_checker_en=1 throughout CHECK and go to SEND_RESP on the cycle i_checker_done=1; o_checker_en SHALL stay 1 through SEND_RESP, WAIT_RESP and DONE so the checker results stay valid.
REQ-022 SHALL, in SEND_RESP, present MSG_CFG_RESP with the same handshake as REQ-018, then go to WAIT_RESP.
REQ-023 SHALL latch a partner-response flag on i_sb_rx_valid=1 with i_sb_rx_msg=MSG_CFG_RESP in any non-IDLE state; WAIT_RESP SHALL go to DONE when this flag is set.
REQ-024 SHALL ignore received codes other than MSG_CFG_REQ/MSG_CFG_RESP; duplicate receptions have no effect.
REQ-025 SHALL run a 16-bit wait counter, cleared on every state change, incremented in SEND_REQ, WAIT_REQ, CHECK, SEND_RESP and WAIT_RESP, and go to ERROR when it reaches TIMEOUT_CYCLES-1 without the exit condition.
REQ-026 SHALL give the exit condition priority when it occurs in the same cycle as the timeout.
REQ-027 SHALL hold o_param_done=1 in DONE and o_param_error=1 in ERROR, drop o_sb_tx_valid there, and stay in DONE or ERROR until i_param_en=0.
REQ-028 SHALL, whenever i_param_en=0 in a non-IDLE state, go to IDLE next cycle, clear both flags and the counter, and drive all outputs 0.
REQ-029 SHALL have a latency of 1 cycle from a qualifying input to the corresponding output change.

Reset
REQ-030 SHALL, while rst_n=0, force IDLE, clear flags and the counter, and drive o_sb_tx_valid, o_sb_tx_msg, o_checker_en, o_param_done and o_param_error to 0.
REQ-031 SHALL take reset asynchronously regardless of CLK, including mid-handshake; after release it stays IDLE until i_param_en=1.

Verification
REQ-032 Nominal: en=1; ack at cycle 3; rx REQ at cycle 5; checker_done 2 cycles after checker_en; ack; rx RESP -> tx REQ then tx RESP, o_param_done=1, o_param_error=0.
REQ-033 Early partner: rx REQ arrives before the own REQ ack -> WAIT_REQ lasts 1 cycle, then o_checker_en=1.
REQ-034 Timeout: TIMEOUT_CYCLES=16, no rx REQ -> o_param_error=1 exactly 16 cycles after WAIT_REQ entry; en=0 -> all outputs 0 next cycle.
REQ-035 Backpressure: ack withheld 10 cycles -> o_sb_tx_valid/o_sb_tx_msg=4'h1 stable all 10 cycles, with a single transfer.
REQ-036 Abort and reset: en=0 during CHECK -> IDLE with o_checker_en=0; rst_n=0 mid-SEND_RESP -> outputs 0 asynchronously, rerun succeeds.
